// File: rtl/fetch_if.sv
// Instruction-memory request/ready bus between the fetch stage and imem.
interface fetch_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata
    );
endinterface

// File: rtl/fetch.sv
// Instruction-fetch stage: owns the PC and IF/ID register, issues imem
// requests, parks a fetched word in a one-entry buffer while stalled, and
// handles decode redirects (including ones that arrive mid-request).
module fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        pc_enable,
    input  logic        if_id_enable,
    input  logic        branch_taken,
    input  logic [31:0] pc_branch_value,
    fetch_if.master     imem,
    output logic [31:0] instruction,
    output logic [31:0] pc,
    output logic        valid_out
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_tgt;        // redirect target waiting for the stale response
    logic        r_pend;
    logic [31:0] r_buf_instr;
    logic [31:0] r_buf_pc;
    logic [31:0] r_instr;
    logic [31:0] r_ifid_pc;
    logic        r_valid;

    logic        w_adv;
    logic        w_xfer;
    logic [31:0] w_target;

    assign w_adv    = pc_enable && if_id_enable;
    assign w_xfer   = (r_state == S_FETCH) && imem.imem_ready;
    // Redirect targets are forced word aligned.
    assign w_target = pc_branch_value & 32'hFFFF_FFFC;

    // The request is held for the whole FETCH state, so req/addr can only
    // change after a transfer; an outstanding request is never withdrawn.
    assign imem.imem_req  = (r_state == S_FETCH);
    assign imem.imem_addr = r_pc;

    assign instruction = r_instr;
    assign pc          = r_ifid_pc;
    assign valid_out   = r_valid;

    // PC, state, buffer, pending redirect and IF/ID register update.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_pc        <= RESET_PC;
            r_tgt       <= 32'h0;
            r_pend      <= 1'b0;
            r_buf_instr <= NOP_INSTR;
            r_buf_pc    <= 32'h0;
            r_instr     <= NOP_INSTR;
            r_ifid_pc   <= 32'h0;
            r_valid     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_state <= S_FETCH;
                    if (branch_taken) begin
                        r_pc    <= w_target;
                        r_instr <= NOP_INSTR;
                        r_valid <= 1'b0;
                    end
                end

                S_FETCH: begin
                    if (w_xfer) begin
                        if (branch_taken) begin
                            // Redirect wins: the returned word is wrong-path.
                            r_pc    <= w_target;
                            r_pend  <= 1'b0;
                            r_instr <= NOP_INSTR;
                            r_valid <= 1'b0;
                        end else if (r_pend) begin
                            // Stale response for a pre-redirect request.
                            r_pc   <= r_tgt;
                            r_pend <= 1'b0;
                            if (if_id_enable) begin
                                r_instr <= NOP_INSTR;
                                r_valid <= 1'b0;
                            end
                        end else if (w_adv) begin
                            r_instr   <= imem.imem_rdata;
                            r_ifid_pc <= r_pc;
                            r_valid   <= 1'b1;
                            r_pc      <= r_pc + 32'd4;
                        end else begin
                            r_buf_instr <= imem.imem_rdata;
                            r_buf_pc    <= r_pc;
                            r_state     <= S_HOLD;
                        end
                    end else begin
                        if (branch_taken) begin
                            // Request must stay stable, so remember the target.
                            r_tgt   <= w_target;
                            r_pend  <= 1'b1;
                            r_instr <= NOP_INSTR;
                            r_valid <= 1'b0;
                        end else if (if_id_enable) begin
                            r_instr <= NOP_INSTR;
                            r_valid <= 1'b0;
                        end
                    end
                end

                S_HOLD: begin
                    if (branch_taken) begin
                        r_pc    <= w_target;
                        r_state <= S_FETCH;
                        r_instr <= NOP_INSTR;
                        r_valid <= 1'b0;
                    end else if (w_adv) begin
                        r_instr   <= r_buf_instr;
                        r_ifid_pc <= r_buf_pc;
                        r_valid   <= 1'b1;
                        r_pc      <= r_pc + 32'd4;
                        r_state   <= S_FETCH;
                    end
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch.sv
// Self-checking bench for fetch: directed test-plan scenarios with literal
// expectations, then randomized stall/ready/redirect traffic against a
// queue-based reference model.
module tb_fetch;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        pc_enable = 1'b1;
    logic        if_id_enable = 1'b1;
    logic        branch_taken = 1'b0;
    logic [31:0] pc_branch_value = 32'h0;
    logic        rdy = 1'b1;
    logic [31:0] instruction, pc;
    logic        valid_out;
    logic [31:0] w_instr, w_pc;
    logic        w_vld;

    int n_checks = 0;
    int n_err    = 0;

    fetch_if if0();
    fetch_if if1();

    always #5 clock = ~clock;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0:   return 32'h00A0_0093;
            32'h4:   return 32'h0010_0113;
            default: return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
        endcase
    endfunction

    assign if0.imem_ready = rdy;
    assign if0.imem_rdata = mem_word(if0.imem_addr);
    assign if1.imem_ready = 1'b1;
    assign if1.imem_rdata = mem_word(if1.imem_addr);

    fetch u_dut (
        .clock           (clock),
        .reset           (reset),
        .pc_enable       (pc_enable),
        .if_id_enable    (if_id_enable),
        .branch_taken    (branch_taken),
        .pc_branch_value (pc_branch_value),
        .imem            (if0),
        .instruction     (instruction),
        .pc              (pc),
        .valid_out       (valid_out)
    );

    fetch #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
        .clock           (clock),
        .reset           (reset),
        .pc_enable       (1'b1),
        .if_id_enable    (1'b1),
        .branch_taken    (1'b0),
        .pc_branch_value (32'h0),
        .imem            (if1),
        .instruction     (w_instr),
        .pc              (w_pc),
        .valid_out       (w_vld)
    );

    // Reference model: "started" flag, PC, a 0/1-entry buffer queue, a
    // 0/1-entry pending-redirect queue, and the visible IF/ID contents.
    logic        m_started;
    logic [31:0] m_pc;
    logic [63:0] m_buf[$];
    logic [31:0] m_redir[$];
    logic [31:0] m_ins, m_ipc;
    logic        m_vld;
    logic        hold_req;
    logic [31:0] hold_addr;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_started = 1'b0;
        m_pc      = 32'h0;
        m_buf.delete();
        m_redir.delete();
        m_ins     = NOP;
        m_ipc     = 32'h0;
        m_vld     = 1'b0;
    endtask

    function automatic logic model_req();
        return m_started && (m_buf.size() == 0);
    endfunction

    task automatic bubble();
        m_ins = NOP;
        m_vld = 1'b0;
    endtask

    task automatic model_step();
        logic [31:0] tgt;
        logic [63:0] e;
        logic        adv;
        tgt = {pc_branch_value[31:2], 2'b00};
        adv = pc_enable && if_id_enable;
        if (!m_started) begin
            m_started = 1'b1;
            if (branch_taken) begin m_pc = tgt; bubble(); end
        end else if (m_buf.size() != 0) begin
            if (branch_taken) begin
                m_buf.delete(); m_pc = tgt; bubble();
            end else if (adv) begin
                e = m_buf.pop_front();
                m_ins = e[63:32]; m_ipc = e[31:0]; m_vld = 1'b1;
                m_pc = m_pc + 32'd4;
            end
        end else if (rdy) begin
            if (branch_taken) begin
                m_redir.delete(); m_pc = tgt; bubble();
            end else if (m_redir.size() != 0) begin
                m_pc = m_redir.pop_front();
                if (if_id_enable) bubble();
            end else if (adv) begin
                m_ins = mem_word(m_pc); m_ipc = m_pc; m_vld = 1'b1;
                m_pc = m_pc + 32'd4;
            end else begin
                m_buf.push_back({mem_word(m_pc), m_pc});
            end
        end else begin
            if (branch_taken) begin
                m_redir.delete(); m_redir.push_back(tgt); bubble();
            end else if (if_id_enable) begin
                bubble();
            end
        end
    endtask

    task automatic compare_all();
        chk("imem_req", {31'h0, if0.imem_req}, {31'h0, model_req()});
        if (model_req()) chk("imem_addr", if0.imem_addr, m_pc);
        chk("instruction", instruction, m_ins);
        chk("pc", pc, m_ipc);
        chk("valid_out", {31'h0, valid_out}, {31'h0, m_vld});
        if (hold_req && reset) begin
            chk("req_stable", {31'h0, if0.imem_req}, 32'h1);
            chk("addr_stable", if0.imem_addr, hold_addr);
        end
    endtask

    // One clock: model advances on the edge, outputs checked on the falling edge.
    task automatic tick();
        hold_req  = reset && if0.imem_req && !rdy;
        hold_addr = if0.imem_addr;
        @(posedge clock);
        if (reset) model_step();
        @(negedge clock);
        compare_all();
    endtask

    task automatic async_reset();
        #2 reset = 1'b0;
        #1;
        chk("arst_valid", {31'h0, valid_out}, 32'h0);
        chk("arst_pc", pc, 32'h0);
        chk("arst_req", {31'h0, if0.imem_req}, 32'h0);
        chk("arst_addr", if0.imem_addr, 32'h0);
        model_reset();
        hold_req = 1'b0;
        compare_all();
        tick();
        reset = 1'b1;
    endtask

    initial begin
        model_reset();
        hold_req = 1'b0;
        tick();
        tick();
        chk("rst_instr", instruction, NOP);
        chk("rst_valid", {31'h0, valid_out}, 32'h0);
        chk("rst_req", {31'h0, if0.imem_req}, 32'h0);
        reset = 1'b1;

        // Reset release, memory always ready.
        tick();
        chk("first_req", {31'h0, if0.imem_req}, 32'h1);
        chk("first_addr", if0.imem_addr, 32'h0);
        chk("wrap_first_addr", if1.imem_addr, 32'hFFFF_FFFC);
        tick();
        chk("w0_instr", instruction, 32'h00A0_0093);
        chk("w0_pc", pc, 32'h0);
        chk("w0_valid", {31'h0, valid_out}, 32'h1);
        chk("wrap_next_addr", if1.imem_addr, 32'h0);
        chk("wrap_pc", w_pc, 32'hFFFF_FFFC);
        chk("wrap_valid", {31'h0, w_vld}, 32'h1);
        chk("wrap_instr", w_instr, mem_word(32'hFFFF_FFFC));
        tick();
        chk("w1_instr", instruction, 32'h0010_0113);
        chk("w1_pc", pc, 32'h4);

        // Three wait states at 0x8.
        rdy = 1'b0;
        repeat (3) begin
            tick();
            chk("wait_addr", if0.imem_addr, 32'h8);
            chk("wait_instr", instruction, NOP);
            chk("wait_valid", {31'h0, valid_out}, 32'h0);
        end
        rdy = 1'b1;
        tick();
        chk("w8_instr", instruction, mem_word(32'h8));
        chk("w8_pc", pc, 32'h8);
        tick();

        // Transfer at 0x10 under a two-cycle stall.
        pc_enable = 1'b0; if_id_enable = 1'b0;
        tick();
        chk("hold_req", {31'h0, if0.imem_req}, 32'h0);
        chk("hold_pc", pc, 32'hC);
        tick();
        chk("hold2_req", {31'h0, if0.imem_req}, 32'h0);
        pc_enable = 1'b1; if_id_enable = 1'b1;
        tick();
        chk("rel_instr", instruction, mem_word(32'h10));
        chk("rel_pc", pc, 32'h10);
        chk("rel_addr", if0.imem_addr, 32'h14);
        repeat (3) tick();
        chk("addr20", if0.imem_addr, 32'h20);

        // Redirect while a request is stalled.
        rdy = 1'b0; branch_taken = 1'b1; pc_branch_value = 32'h103;
        tick();
        chk("br_flush_valid", {31'h0, valid_out}, 32'h0);
        chk("br_keep_addr", if0.imem_addr, 32'h20);
        branch_taken = 1'b0; rdy = 1'b1;
        tick();
        chk("br_discard_valid", {31'h0, valid_out}, 32'h0);
        chk("br_new_addr", if0.imem_addr, 32'h100);

        // Redirect coincident with a transfer and a stall.
        pc_enable = 1'b0; if_id_enable = 1'b0; branch_taken = 1'b1; pc_branch_value = 32'h200;
        tick();
        chk("brx_valid", {31'h0, valid_out}, 32'h0);
        chk("brx_req", {31'h0, if0.imem_req}, 32'h1);
        chk("brx_addr", if0.imem_addr, 32'h200);
        branch_taken = 1'b0; pc_enable = 1'b1; if_id_enable = 1'b1;
        tick();
        chk("brx_instr", instruction, mem_word(32'h200));
        chk("brx_pc", pc, 32'h200);

        // Asynchronous reset during a wait state with a valid IF/ID.
        rdy = 1'b0; if_id_enable = 1'b0;
        tick();
        chk("pre_arst_valid", {31'h0, valid_out}, 32'h1);
        if_id_enable = 1'b1;
        async_reset();

        // Randomized traffic.
        for (int i = 0; i < 4000; i++) begin
            rdy             = ($urandom_range(99, 0) < 65);
            pc_enable       = ($urandom_range(99, 0) < 80);
            if_id_enable    = ($urandom_range(99, 0) < 80);
            branch_taken    = ($urandom_range(99, 0) < 6);
            pc_branch_value = $urandom();
            if ($urandom_range(499, 0) == 0) async_reset();
            else tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule

// File: doc/fetch.md
Name: fetch

Overview:
- Instruction-fetch (IF) stage of the 5-stage RISC-V pipeline. Sits directly upstream of the decode stage.
- Owns the PC register and the IF/ID pipeline register, and drives a request/ready instruction-memory interface.
- Obeys the hazard unit's pc_enable/if_id_enable stall controls and the decode stage's branch redirect (branch_taken, pc_branch_value).
- Holds a one-entry buffer so that a fetched word is never lost while the pipeline is stalled.

Parameters:
- RESET_PC, 32'h00000000, PC value loaded on reset.
- NOP_INSTR, 32'h00000013, bubble encoding (addi x0,x0,0) placed in IF/ID on flush or empty fetch.

Ports:
- clock  in  1  pipeline clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- pc_enable  in  1  from hazard unit; 0 = PC must not advance.
- if_id_enable  in  1  from hazard unit; 0 = IF/ID register holds.
- branch_taken  in  1  redirect request from decode; valid for one cycle.
- pc_branch_value  in  32  redirect target.
- imem_req  out  1  fetch request.
- imem_addr  out  32  fetch address; word aligned.
- imem_ready  in  1  memory accepts and returns data this cycle.
- imem_rdata  in  32  instruction word; valid when imem_req && imem_ready.
- instruction  out  32  IF/ID instruction to decode.
- pc  out  32  IF/ID PC of that instruction.
- valid_out  out  1  1 = IF/ID holds a real instruction; 0 = bubble.

Behaviour:
- Reset (reset=0, asynchronous):
  - pc_reg=RESET_PC, state=IDLE, redirect_pending=0, buffer empty.
  - instruction=NOP_INSTR, pc=0, valid_out=0, imem_req=0.
- States:
  - IDLE: one cycle after reset deasserts, then FETCH.
  - FETCH: imem_req=1, imem_addr=pc_reg.
  - HOLD: a word is buffered; imem_req=0.
- Transfer:
  - A transfer is imem_req && imem_ready; zero added latency, data sampled the same cycle.
  - imem_req and imem_addr stay stable from assertion until the transfer; a request is never withdrawn.
- Advance condition: adv = pc_enable && if_id_enable.
- FETCH, transfer, no redirect:
  - If adv: IF/ID <= {imem_rdata, pc_reg, valid=1}; pc_reg <= pc_reg+4; stay in FETCH.
  - If !adv: buffer <= {imem_rdata, pc_reg}; go to HOLD; IF/ID unchanged.
- FETCH, no transfer:
  - If if_id_enable: IF/ID <= bubble (NOP_INSTR, valid=0, pc unchanged).
  - Otherwise IF/ID holds.
- HOLD:
  - If adv: IF/ID <= buffer with valid=1; pc_reg <= pc_reg+4; go to FETCH.
  - Otherwise hold everything.
- Redirect (branch_taken=1) has priority over stalls:
  - IF/ID is flushed to a bubble regardless of if_id_enable.
  - Target is {pc_branch_value[31:2], 2'b00}; bits [1:0] are forced to 0.
  - In FETCH with no transfer this cycle: latch target, set redirect_pending=1, keep the outstanding request unchanged.
  - In FETCH with a transfer this cycle: discard imem_rdata; pc_reg <= target.
  - In HOLD: drop the buffer; pc_reg <= target; go to FETCH.
  - In IDLE: pc_reg <= target.
- redirect_pending=1:
  - The next transfer's data is discarded; pc_reg <= latched target; redirect_pending <= 0.
  - While pending, IF/ID only ever receives bubbles.
  - A second branch_taken while pending overwrites the latched target.
- Arithmetic: pc_reg+4 wraps modulo 2^32 (0xFFFFFFFC -> 0x00000000).
- Outputs are registered; instruction, pc and valid_out change only on a clock edge or on reset.
- Reset mid-operation: everything returns to reset values immediately; any in-flight response is ignored. Memory must treat imem_req falling as cancellation only under reset.

Test Plan:
- Reset release, memory always ready, words 0x00A00093, 0x00100113 at 0x0/0x4 -> imem_req rises 1 cycle after IDLE; IF/ID shows (0x00A00093, pc 0x0, valid 1), then (0x00100113, 0x4, 1) on consecutive cycles.
- imem_ready low for 3 cycles on addr 0x8 -> imem_addr stays 0x8 throughout, 3 bubbles (NOP, valid 0), then the word at 0x8 appears.
- Transfer at addr 0x10 with pc_enable=if_id_enable=0 for 2 cycles -> state HOLD, imem_req=0, IF/ID unchanged; on release IF/ID = (word@0x10, 0x10, 1) and the next fetch addr is 0x14.
- branch_taken with pc_branch_value=0x103 while a request at 0x20 is stalled -> IF/ID flushed to bubble; the word returned for 0x20 is discarded; next imem_addr=0x100.
- branch_taken in the same cycle as a transfer and a stall -> flush takes priority; valid_out=0, pc_reg=target, no buffered word.
- RESET_PC=0xFFFFFFFC -> after the first fetch the next imem_addr=0x00000000. Asserting reset during a wait-state -> valid_out=0 and pc_reg=RESET_PC asynchronously.
